// File: rtl/axi_rd_arb_pkg.sv
// Shared types and AXI constants for the two-requester read-channel arbiter.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [3:0] ARID_ICACHE    = 4'd0;
    localparam logic [3:0] ARID_DCACHE    = 4'd1;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read address/data channel bundle between the arbiter (master) and the bridge (slave).
interface axi_rd_arbiter_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_rd_arb_pick.sv
// Two-way requester chooser. AXI_RD_ARB_RR_EN selects round-robin with a
// registered last-served pointer; otherwise D-cache wins every tie.
module axi_rd_arb_pick (
`ifdef AXI_RD_ARB_RR_EN
    input  logic clk,
    input  logic rstn,
    input  logic take,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic pick_d
);

`ifdef AXI_RD_ARB_RR_EN
    logic last_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_d <= 1'b0;
        end else if (take) begin
            last_d <= pick_d;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_d = d_req;
        if (i_req && d_req) begin
            pick_d = !last_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between the I-cache and D-cache refill engines,
// one burst at a time; round-robin ties when AXI_RD_ARB_RR_EN is defined.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_rd_req,
    input  logic [31:0]              i_rd_addr,
    input  logic [7:0]               i_rd_len,
    output logic                     i_rd_rdy,
    input  logic                     i_data_ready,
    output logic                     i_ret_valid,
    output logic                     i_ret_last,
    input  logic                     d_rd_req,
    input  logic [31:0]              d_rd_addr,
    input  logic [7:0]               d_rd_len,
    output logic                     d_rd_rdy,
    input  logic                     d_data_ready,
    output logic                     d_ret_valid,
    output logic                     d_ret_last,
    output logic [31:0]              ret_data,
    axi_rd_arbiter_if.master         axi
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        owner_d;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic        take;
    logic        pick_d;
    logic        arvalid;
    logic        rready;
    logic        unused_rsp;

    axi_rd_arb_pick u_pick (
`ifdef AXI_RD_ARB_RR_EN
        .clk    (clk),
        .rstn   (rstn),
        .take   (take),
`endif
        .i_req  (i_rd_req),
        .d_req  (d_rd_req),
        .pick_d (pick_d)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner_d <= pick_d;
                addr_q  <= pick_d ? d_rd_addr : i_rd_addr;
                len_q   <= pick_d ? d_rd_len  : i_rd_len;
            end
        end
    end

    // Return path is purely combinational; only the latched owner sees beats.
    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        ret_data    = '0;
        case (state)
            IDLE: begin
                if (i_rd_req || d_rd_req) begin
                    take      = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (axi.arready) begin
                    i_rd_rdy  = !owner_d;
                    d_rd_rdy  = owner_d;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                rready      = owner_d ? d_data_ready : i_data_ready;
                ret_data    = axi.rdata;
                i_ret_valid = !owner_d && axi.rvalid;
                i_ret_last  = !owner_d && axi.rlast;
                d_ret_valid = owner_d && axi.rvalid;
                d_ret_last  = owner_d && axi.rlast;
                if (axi.rvalid && rready && axi.rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign axi.arvalid = arvalid;
    assign axi.rready  = rready;
    assign axi.arid    = owner_d ? ARID_DCACHE : ARID_ICACHE;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;

    // Routing never depends on the returned ID or response code.
    assign unused_rsp = ^{axi.rid, axi.rresp};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized
// bursts checked against a transaction-level model of grant order and beat delivery.
module tb_axi_rd_arbiter;

    logic        clk;
    logic        rstn;
    logic        i_rd_req, d_rd_req;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic [7:0]  i_rd_len, d_rd_len;
    logic        i_rd_rdy, d_rd_rdy;
    logic        i_data_ready, d_data_ready;
    logic        i_ret_valid, d_ret_valid;
    logic        i_ret_last, d_ret_last;
    logic [31:0] ret_data;

    axi_rd_arbiter_if axi ();

    axi_rd_arbiter dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_rd_req     (i_rd_req),
        .i_rd_addr    (i_rd_addr),
        .i_rd_len     (i_rd_len),
        .i_rd_rdy     (i_rd_rdy),
        .i_data_ready (i_data_ready),
        .i_ret_valid  (i_ret_valid),
        .i_ret_last   (i_ret_last),
        .d_rd_req     (d_rd_req),
        .d_rd_addr    (d_rd_addr),
        .d_rd_len     (d_rd_len),
        .d_rd_rdy     (d_rd_rdy),
        .d_data_ready (d_data_ready),
        .d_ret_valid  (d_ret_valid),
        .d_ret_last   (d_ret_last),
        .ret_data     (ret_data),
        .axi          (axi.master)
    );

    int          tests = 0;
    int          fails = 0;
    bit          lastServedD;
    bit          iHold, dHold;
    logic [31:0] iAddr, dAddr;
    logic [7:0]  iLen, dLen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit iReq, input bit dReq, input bit iReady, input bit dReady,
                                 input bit arRdy, input bit rv, input bit rl, input logic [31:0] rd,
                                 input bit rstVal);
        @(negedge clk);
        rstn         = rstVal;
        i_rd_req     = iReq;
        d_rd_req     = dReq;
        i_rd_addr    = iAddr;
        d_rd_addr    = dAddr;
        i_rd_len     = iLen;
        d_rd_len     = dLen;
        i_data_ready = iReady;
        d_data_ready = dReady;
        axi.arready  = arRdy;
        axi.rvalid   = rv;
        axi.rlast    = rl;
        axi.rdata    = rd;
        axi.rid      = 4'($urandom);
        axi.rresp    = 2'($urandom);
        #1;
    endtask

    // Grant rule: a lone requester wins; ties go to D (fixed) or to the one not served last (RR).
    function automatic bit pickD(input bit iq, input bit dq);
        if (iq && dq) begin
`ifdef AXI_RD_ARB_RR_EN
            return !lastServedD;
`else
            return 1'b1;
`endif
        end
        return dq;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_arvalid"}, axi.arvalid, 0);
        checkOutput({tag, "_rready"}, axi.rready, 0);
        checkOutput({tag, "_rdy"}, {i_rd_rdy, d_rd_rdy}, 0);
        checkOutput({tag, "_valid"}, {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last}, 0);
    endtask

    task automatic doReset();
        iHold = 1'b0;
        dHold = 1'b0;
        lastServedD = 1'b0;
        applyStimulus(0, 0, 1, 1, 1, 1, 1, 32'hDEADBEEF, 0);
        applyStimulus(0, 0, 1, 1, 1, 1, 1, 32'hDEADBEEF, 0);
        checkIdle("reset");
        checkOutput("reset_arid", axi.arid, 0);
        checkOutput("reset_araddr", axi.araddr, 0);
        checkOutput("reset_arlen", axi.arlen, 0);
        checkOutput("reset_arsize", axi.arsize, 3'b010);
        checkOutput("reset_arburst", axi.arburst, 2'b01);
        checkOutput("reset_ret_data", ret_data, 0);
    endtask

    task automatic runBurst(input int stall, input int bpBeat, input int abortBeat);
        bit          wantD;
        bit          done;
        bit          ar, own, oth, rv, rl, bpDone;
        int          beat, bpLeft;
        logic [31:0] expAddr, rd;
        logic [7:0]  expLen;
        logic [31:0] data[$];

        wantD       = pickD(iHold, dHold);
        lastServedD = wantD;
        expAddr     = wantD ? dAddr : iAddr;
        expLen      = wantD ? dLen : iLen;

        applyStimulus(iHold, dHold, 1, 1, 0, 0, 0, $urandom, 1);
        checkOutput("idle_arvalid", axi.arvalid, 0);
        checkOutput("idle_rdy", {i_rd_rdy, d_rd_rdy}, 0);

        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            ar = (k >= stall);
            applyStimulus(iHold, dHold, 1, 1, ar, 0, 0, $urandom, 1);
            checkOutput("ar_arvalid", axi.arvalid, 1);
            checkOutput("ar_arid", axi.arid, wantD ? 1 : 0);
            checkOutput("ar_araddr", axi.araddr, expAddr);
            checkOutput("ar_arlen", axi.arlen, expLen);
            checkOutput("ar_arsize", axi.arsize, 3'b010);
            checkOutput("ar_arburst", axi.arburst, 2'b01);
            checkOutput("ar_i_rd_rdy", i_rd_rdy, ar && !wantD);
            checkOutput("ar_d_rd_rdy", d_rd_rdy, ar && wantD);
            checkOutput("ar_rready", axi.rready, 0);
            if (ar) begin
                done = 1'b1;
                if (wantD) dHold = 1'b0;
                else iHold = 1'b0;
            end
        end
        if (!done) begin
            checkOutput("ar_timeout", 0, 1);
            doReset();
            return;
        end

        for (int k = 0; k <= int'(expLen); k++) data.push_back($urandom);
        beat   = 0;
        bpLeft = 0;
        bpDone = 1'b0;
        done   = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            if (beat == bpBeat && !bpDone) begin
                bpLeft = 3;
                bpDone = 1'b1;
            end
            own = (bpLeft > 0) ? 1'b0 : ($urandom % 4 != 0);
            oth = $urandom % 2;
            rv  = ($urandom % 5 != 0);
            rl  = rv && (beat == int'(expLen));
            rd  = rv ? data[beat] : $urandom;
            applyStimulus(iHold, dHold, wantD ? oth : own, wantD ? own : oth, 0, rv, rl, rd,
                          !(rv && beat == abortBeat));
            checkOutput("r_rready", axi.rready, own);
            checkOutput("r_i_ret_valid", i_ret_valid, !wantD && rv);
            checkOutput("r_d_ret_valid", d_ret_valid, wantD && rv);
            checkOutput("r_i_ret_last", i_ret_last, !wantD && rl);
            checkOutput("r_d_ret_last", d_ret_last, wantD && rl);
            checkOutput("r_arvalid", axi.arvalid, 0);
            if (rv) checkOutput("r_ret_data", ret_data, data[beat]);
            if (rv && beat == abortBeat) begin
                iHold = 1'b0;
                dHold = 1'b0;
                lastServedD = 1'b0;
                applyStimulus(0, 0, 1, 1, 1, 1, 0, $urandom, 1);
                checkIdle("abort");
                checkOutput("abort_arid", axi.arid, 0);
                checkOutput("abort_araddr", axi.araddr, 0);
                checkOutput("abort_arlen", axi.arlen, 0);
                return;
            end
            if (bpLeft > 0) bpLeft--;
            if (rv && own) begin
                if (rl) done = 1'b1;
                beat++;
            end
        end
        if (!done) begin
            checkOutput("r_timeout", 0, 1);
            doReset();
        end
    endtask

    initial begin
        iAddr = '0; dAddr = '0; iLen = '0; dLen = '0;
        doReset();

        // I-cache alone, 16-beat refill, then two idle cycles.
        iHold = 1; iAddr = 32'h1C000040; iLen = 8'd15;
        runBurst(0, -1, -1);
        applyStimulus(0, 0, 1, 1, 1, 0, 0, $urandom, 1);
        checkIdle("post_i");
        applyStimulus(0, 0, 1, 1, 1, 0, 0, $urandom, 1);
        checkIdle("post_i2");

        // Simultaneous requests, then D re-requests while I is still waiting.
        iHold = 1; iAddr = 32'h00001000; iLen = 8'd2;
        dHold = 1; dAddr = 32'h80002000; dLen = 8'd3;
        runBurst(0, -1, -1);
        dHold = 1; dAddr = 32'h80003000; dLen = 8'd1;
        runBurst(0, -1, -1);
        runBurst(0, -1, -1);

        // Address phase stalled for five cycles.
        dHold = 1; dAddr = 32'h40000010; dLen = 8'd2;
        runBurst(5, -1, -1);

        // Uncached single-beat D read.
        dHold = 1; dAddr = 32'h9FD00000; dLen = 8'd0;
        runBurst(0, -1, -1);

        // D backpressure for three cycles mid-burst.
        dHold = 1; dAddr = 32'h00004000; dLen = 8'd7;
        runBurst(1, 4, -1);

        // Reset while the eighth beat is on the bus, then a clean I refill.
        iHold = 1; iAddr = 32'h1C000080; iLen = 8'd15;
        runBurst(0, -1, 7);
        iHold = 1; iAddr = 32'h1C0000C0; iLen = 8'd3;
        runBurst(0, -1, -1);

        for (int n = 0; n < 12; n++) begin
            if (!iHold && ($urandom % 2 == 1)) begin
                iHold = 1; iAddr = $urandom & 32'hFFFFFFFC; iLen = 8'($urandom_range(0, 7));
            end
            if (!dHold && ($urandom % 2 == 1)) begin
                dHold = 1; dAddr = $urandom & 32'hFFFFFFFC; dLen = 8'($urandom_range(0, 7));
            end
            if (!iHold && !dHold) begin
                iHold = 1; iAddr = $urandom & 32'hFFFFFFFC; iLen = 8'($urandom_range(0, 7));
            end
            runBurst($urandom_range(0, 3), ($urandom % 2 == 1) ? $urandom_range(0, 7) : -1, -1);
        end
        for (int n = 0; n < 2; n++) begin
            if (iHold || dHold) runBurst(0, -1, -1);
        end
        applyStimulus(0, 0, 1, 1, 1, 0, 0, $urandom, 1);
        checkIdle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
